register_file: RTL and testbench



---
 rtl/register_file.sv | 78 +++++++
 tb/tb_register_file.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
//------------------------------------------------------------------------------
// Module   : register_file
// Brief    : 32x32 RISC-V integer register file, x0 hardwired to zero, two
//            combinational read ports, one synchronous write port, debug read.
//            Optional build macro REGFILE_BYPASS_EN adds write-through
//            forwarding on rd1/rd2 (never on dbg_data).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = '0;

    logic [DATA_WIDTH-1:0] w_entry [NUM_REGS];
    logic                  w_wr_en;

    generate
        if (ADDR_WIDTH != $clog2(NUM_REGS) || NUM_REGS != (1 << ADDR_WIDTH)) begin : g_param_check
            $error("register_file: NUM_REGS must be a power of two equal to 2**ADDR_WIDTH");
        end
    endgenerate

    // Gating with rst keeps the bypass path quiet during reset as well.
    assign w_wr_en = reg_write && (rd != c_ZERO_IDX) && !rst;

    assign w_entry[0] = '0;

    generate
        for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_wr_en && (rd == ADDR_WIDTH'(i))) begin
                    r_q <= wd;
                end
            end

            assign w_entry[i] = r_q;
        end
    endgenerate

    always_comb begin
        rd1 = w_entry[rs1];
        rd2 = w_entry[rs2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (rd == rs1)) begin
            rd1 = wd;
        end
        if (w_wr_en && (rd == rs2)) begin
            rd2 = wd;
        end
`endif
    end

    assign dbg_data = w_entry[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
//------------------------------------------------------------------------------
// Module   : tb_register_file
// Brief    : Directed self-checking bench for register_file (either build).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        reg_write;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks;
    int n_fail;

    register_file #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .wd        (wd),
        .reg_write (reg_write),
        .rd1       (rd1),
        .rd2       (rd2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rd        = a;
        wd        = d;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
    endtask

    // Reference ALU for the integration check: only ADD is needed here.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op == 4'b0010) ? a + b : 32'h0;
    endfunction

    logic [31:0] alu_out;
    logic [31:0] exp_val;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        rs1       = 5'd5;
        rs2       = 5'd0;
        rd        = 5'd5;
        wd        = 32'h1;
        reg_write = 1'b1;
        dbg_addr  = 5'd5;

        // Writes attempted during power-on reset must be ignored.
        repeat (3) @(posedge clk);
        #1;
        check("por_rd1", rd1, 32'h0);
        check("por_rd2", rd2, 32'h0);
        check("por_dbg", dbg_data, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        rst       = 1'b0;

        // First edge after release accepts a write.
        write_reg(5'd6, 32'hCAFE0006);
        dbg_addr = 5'd6;
        #1;
        check("first_write", dbg_data, 32'hCAFE0006);

        // Asynchronous reset clears without an edge; write at reset edge dropped.
        write_reg(5'd5, 32'hDEADBEEF);
        rs1 = 5'd5;
        #1;
        check("preload_x5", rd1, 32'hDEADBEEF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", rd1, 32'h0);
        rd        = 5'd5;
        wd        = 32'h12345678;
        reg_write = 1'b1;
        @(posedge clk);
        #1;
        dbg_addr = 5'd5;
        #1;
        check("rst_blocks_write", dbg_data, 32'h0);
        @(negedge clk);
        reg_write = 1'b0;
        rst       = 1'b0;

        // x0 protection.
        write_reg(5'd0, 32'hFFFFFFFF);
        rs1      = 5'd0;
        dbg_addr = 5'd0;
        #1;
        check("x0_rd1", rd1, 32'h0);
        check("x0_dbg", dbg_data, 32'h0);

        // Fill and sweep every register on all three read ports.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            rs1      = 5'(i);
            rs2      = 5'(31 - i);
            dbg_addr = 5'(i);
            #1;
            exp_val = 32'(i) * 32'h01010101;
            check($sformatf("sweep_rd1[%0d]", i), rd1, exp_val);
            check($sformatf("sweep_dbg[%0d]", i), dbg_data, exp_val);
            exp_val = 32'(31 - i) * 32'h01010101;
            check($sformatf("sweep_rd2[%0d]", 31 - i), rd2, exp_val);
        end
        rs1 = 5'd17;
        rs2 = 5'd17;
        #1;
        check("same_idx_rd1", rd1, 32'h11111111);
        check("same_idx_rd2", rd2, 32'h11111111);

        // Write enable low: state unchanged across several edges.
        write_reg(5'd3, 32'd7);
        @(negedge clk);
        rd        = 5'd3;
        wd        = 32'd99;
        reg_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dbg_addr = 5'd3;
        #1;
        check("we_low_x3", dbg_data, 32'd7);

        // Same-cycle read/write hazard on x9.
        write_reg(5'd9, 32'd10);
        @(negedge clk);
        rs1       = 5'd9;
        rs2       = 5'd9;
        dbg_addr  = 5'd9;
        rd        = 5'd9;
        wd        = 32'd42;
        reg_write = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_pre_rd1", rd1, 32'd42);
        check("hazard_pre_rd2", rd2, 32'd42);
`else
        check("hazard_pre_rd1", rd1, 32'd10);
        check("hazard_pre_rd2", rd2, 32'd10);
`endif
        check("hazard_pre_dbg", dbg_data, 32'd10);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        check("hazard_post_rd1", rd1, 32'd42);
        check("hazard_post_dbg", dbg_data, 32'd42);

        // Back-to-back writes: last edge wins.
        write_reg(5'd7, 32'h1);
        write_reg(5'd7, 32'h2);
        dbg_addr = 5'd7;
        #1;
        check("b2b_x7", dbg_data, 32'h2);

        // ALU integration: x3 = x1 + x2.
        write_reg(5'd1, 32'd123894);
        write_reg(5'd2, 32'd2479);
        rs1 = 5'd1;
        rs2 = 5'd2;
        #1;
        check("alu_opa", rd1, 32'd123894);
        check("alu_opb", rd2, 32'd2479);
        alu_out = alu_model(4'b0010, rd1, rd2);
        write_reg(5'd3, alu_out);
        dbg_addr = 5'd3;
        #1;
        check("alu_wb_x3", dbg_data, 32'd126373);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
